pretrigger_receiver: RTL and testbench

- Consumer of the periodic pre-trigger pulse train produced by the pre-trigger generator.
- Qualifies each pulse by width, timestamps it, waits a programmable latency, then opens an acquisition window for the digitizer buffer.
- Presents one event record per accepted trigger on a valid/ready handshake to the readout logic.
- Keeps trigger, drop and width-error counters for slow control.

---
 rtl/pretrigger_receiver.sv | 152 +++++++++++++++
 tb/tb_pretrigger_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pretrigger_receiver.sv
// Pre-trigger receiver: width-qualifies trigger pulses, timestamps them, opens a
// delayed acquisition window and hands one event record per trigger to readout.
module pretrigger_receiver #(
  parameter int MIN_W = 2,
  parameter int MAX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        trig_in,
  input  logic [7:0]  latency,
  input  logic [7:0]  win_len,
  output logic        acq_win,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_id,
  output logic [31:0] evt_ts,
  output logic [15:0] trig_cnt,
  output logic [15:0] drop_cnt,
  output logic [7:0]  werr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WINDOW, S_REPORT} state_t;

  localparam logic [3:0] LP_MIN = 4'(MIN_W);
  localparam logic [3:0] LP_MAX = 4'(MAX_W);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      r_state;
  logic        r_trig_d;
  logic [31:0] r_ts;
  logic [31:0] r_ts_lat;
  logic [3:0]  r_width;
  logic [7:0]  r_dly;
  logic [7:0]  r_wcnt;
  logic [15:0] r_id_next;

  logic       w_rise;
  logic       w_fall;
  logic       w_width_ok;
  logic       w_qual;
  logic       w_accept;
  logic       w_drop;
  logic       w_werr;
  logic [7:0] w_win_eff;

  assign w_rise     = trig_in & ~r_trig_d;
  assign w_fall     = ~trig_in & r_trig_d;
  assign w_width_ok = (r_width >= LP_MIN) && (r_width <= LP_MAX);
  assign w_qual     = w_fall && w_width_ok;
  assign w_accept   = w_qual && ena && (r_state == S_IDLE);
  assign w_drop     = w_qual && ena && (r_state != S_IDLE);
  assign w_werr     = w_fall && ena && !w_width_ok;
  assign w_win_eff  = (win_len == 8'd0) ? 8'd1 : win_len;

  // Edge detection, free-running timestamp and pulse-width measurement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig_d <= 1'b0;
      r_ts     <= 32'd0;
      r_ts_lat <= 32'd0;
      r_width  <= 4'd0;
    end else begin
      r_trig_d <= trig_in;
      r_ts     <= r_ts + 32'd1;
      if (w_rise) begin
        r_ts_lat <= r_ts;
        r_width  <= 4'd1;
      end else if (trig_in && r_width != 4'hF) begin
        r_width <= r_width + 4'd1;
      end
    end
  end

  // Slow-control counters; the event number wraps independently of trig_cnt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_cnt  <= 16'd0;
      drop_cnt  <= 16'd0;
      werr_cnt  <= 8'd0;
      r_id_next <= 16'd0;
    end else begin
      if (w_accept) begin
        trig_cnt  <= sat_inc16(trig_cnt);
        r_id_next <= r_id_next + 16'd1;
      end
      if (w_drop) drop_cnt <= sat_inc16(drop_cnt);
      if (w_werr) werr_cnt <= sat_inc8(werr_cnt);
    end
  end

  // Event sequencer: delay, window, then hold the record until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_dly     <= 8'd0;
      r_wcnt    <= 8'd0;
      acq_win   <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= 16'd0;
      evt_ts    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            evt_id <= r_id_next;
            evt_ts <= r_ts_lat;
            if (latency == 8'd0) begin
              r_state <= S_WINDOW;
              r_wcnt  <= w_win_eff;
            end else begin
              r_state <= S_DELAY;
              r_dly   <= latency;
            end
          end
        end
        S_DELAY: begin
          r_dly <= r_dly - 8'd1;
          if (r_dly == 8'd1) begin
            r_state <= S_WINDOW;
            r_wcnt  <= w_win_eff;
          end
        end
        S_WINDOW: begin
          if (r_wcnt != 8'd0) begin
            acq_win <= 1'b1;
            r_wcnt  <= r_wcnt - 8'd1;
          end else begin
            acq_win   <= 1'b0;
            evt_valid <= 1'b1;
            r_state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pretrigger_receiver.sv
// Directed bench for pretrigger_receiver: inputs change and outputs are sampled
// on the falling clock edge; expected values are hand-derived per step.
module tb_pretrigger_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        trig_in = 1'b0;
  logic [7:0]  latency = 8'd0;
  logic [7:0]  win_len = 8'd0;
  logic        evt_ready = 1'b0;
  logic        acq_win;
  logic        evt_valid;
  logic [15:0] evt_id;
  logic [31:0] evt_ts;
  logic [15:0] trig_cnt;
  logic [15:0] drop_cnt;
  logic [7:0]  werr_cnt;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] tmr_model;
  logic [31:0] exp_ts;
  logic [31:0] ts_a;
  logic [15:0] id_hold;
  logic [31:0] ts_hold;
  bit          stable;
  bit          acq_seen;
  int          acq_n;

  pretrigger_receiver #(.MIN_W(2), .MAX_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .trig_in(trig_in),
    .latency(latency), .win_len(win_len),
    .acq_win(acq_win), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_ts(evt_ts),
    .trig_cnt(trig_cnt), .drop_cnt(drop_cnt), .werr_cnt(werr_cnt)
  );

  always #5 clk = ~clk;

  // Reference free-running timer: value just before an edge is the count of prior edges
  always @(posedge clk or negedge rst)
    if (!rst) tmr_model <= 32'd0;
    else      tmr_model <= tmr_model + 32'd1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // High for w edges starting at the next edge (R); returns just after edge F
  task automatic pulse(input int w);
    trig_in = 1'b1;
    exp_ts  = tmr_model;
    tick(w);
    trig_in = 1'b0;
    tick(1);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget && !evt_valid; i++) begin
      tick(1);
      if (acq_win) n++;
    end
    chk("valid_timeout", 32'(evt_valid), 32'd1);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (evt_id !== id_hold || evt_ts !== ts_hold || evt_valid !== 1'b1) stable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("rst_acq",  32'(acq_win),   32'd0);
    chk("rst_vld",  32'(evt_valid), 32'd0);
    chk("rst_trig", 32'(trig_cnt),  32'd0);
    chk("rst_drop", 32'(drop_cnt),  32'd0);
    chk("rst_werr", 32'(werr_cnt),  32'd0);
    chk("rst_ts",   evt_ts,         32'd0);
    rst = 1'b1;
    ena = 1'b1;
    tick(2);

    // Basic event: latency 5, window 4, width 3
    latency = 8'd5; win_len = 8'd4;
    pulse(3);
    chk("t1_acq_F", 32'(acq_win), 32'd0);
    tick(5);
    chk("t1_acq_F5", 32'(acq_win), 32'd0);
    tick(1);
    chk("t1_acq_F6", 32'(acq_win), 32'd1);
    tick(3);
    chk("t1_acq_F9", 32'(acq_win), 32'd1);
    chk("t1_vld_F9", 32'(evt_valid), 32'd0);
    tick(1);
    chk("t1_acq_F10", 32'(acq_win), 32'd0);
    chk("t1_vld_F10", 32'(evt_valid), 32'd1);
    chk("t1_id", 32'(evt_id), 32'd0);
    chk("t1_ts", evt_ts, exp_ts);
    chk("t1_trig", 32'(trig_cnt), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("t1_vld_drop", 32'(evt_valid), 32'd0);

    // Width rejection: 1 (short), 5 (long), 20 (saturating width counter)
    acq_seen = 1'b0;
    pulse(1); tick(2);
    pulse(5); tick(2);
    pulse(20);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (acq_win) acq_seen = 1'b1;
    end
    chk("t2_no_acq", 32'(acq_seen), 32'd0);
    chk("t2_werr", 32'(werr_cnt), 32'd3);
    chk("t2_trig", 32'(trig_cnt), 32'd1);
    chk("t2_vld", 32'(evt_valid), 32'd0);

    // Busy drop: second pulse 8 cycles after the first, during the delay
    latency = 8'd20; win_len = 8'd2;
    pulse(3);
    ts_a = exp_ts;
    tick(4);
    pulse(3);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    wait_valid(60, acq_n);
    chk("t3_acq_len", 32'(acq_n), 32'd2);
    chk("t3_id", 32'(evt_id), 32'd1);
    chk("t3_ts", evt_ts, ts_a);
    chk("t3_trig", 32'(trig_cnt), 32'd2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("t3_vld_drop", 32'(evt_valid), 32'd0);

    // Backpressure: 50 cycles of evt_ready low with three pulses arriving
    latency = 8'd0; win_len = 8'd1;
    pulse(2);
    ts_a = exp_ts;
    wait_valid(20, acq_n);
    chk("t4_id", 32'(evt_id), 32'd2);
    chk("t4_ts", evt_ts, ts_a);
    id_hold = evt_id; ts_hold = evt_ts; stable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pulse(3);
      hold(4);
    end
    hold(26);
    chk("t4_stable", 32'(stable), 32'd1);
    chk("t4_drop", 32'(drop_cnt), 32'd4);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("t4_vld_drop", 32'(evt_valid), 32'd0);
    chk("t4_trig", 32'(trig_cnt), 32'd3);

    // latency 0 / win_len 0: single-cycle window right after F+1
    latency = 8'd0; win_len = 8'd0;
    pulse(2);
    chk("t5_acq_F", 32'(acq_win), 32'd0);
    tick(1);
    chk("t5_acq_F1", 32'(acq_win), 32'd1);
    tick(1);
    chk("t5_acq_F2", 32'(acq_win), 32'd0);
    chk("t5_vld", 32'(evt_valid), 32'd1);
    chk("t5_id", 32'(evt_id), 32'd3);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;

    // ena low: valid, short and long pulses are all ignored
    ena = 1'b0;
    pulse(3); tick(1);
    pulse(1); tick(1);
    pulse(6);
    tick(5);
    chk("t5_off_trig", 32'(trig_cnt), 32'd4);
    chk("t5_off_drop", 32'(drop_cnt), 32'd4);
    chk("t5_off_werr", 32'(werr_cnt), 32'd3);
    chk("t5_off_vld", 32'(evt_valid), 32'd0);

    // ena dropped after acceptance: the sequence still completes
    ena = 1'b1; latency = 8'd3; win_len = 8'd2;
    pulse(4);
    ena = 1'b0;
    wait_valid(20, acq_n);
    chk("t5_mid_id", 32'(evt_id), 32'd4);
    chk("t5_mid_acq", 32'(acq_n), 32'd2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    ena = 1'b1;

    // Asynchronous reset in the middle of a window
    latency = 8'd2; win_len = 8'd10;
    pulse(3);
    tick(3);
    chk("t6_acq_on", 32'(acq_win), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_acq", 32'(acq_win), 32'd0);
    chk("t6_vld", 32'(evt_valid), 32'd0);
    chk("t6_trig", 32'(trig_cnt), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_werr", 32'(werr_cnt), 32'd0);
    chk("t6_id_clr", 32'(evt_id), 32'd0);
    #1 rst = 1'b1;
    tick(3);
    pulse(4);
    ts_a = exp_ts;
    wait_valid(20, acq_n);
    chk("t6_acq_len", 32'(acq_n), 32'd10);
    chk("t6_id", 32'(evt_id), 32'd0);
    chk("t6_ts", evt_ts, ts_a);
    chk("t6_trig_after", 32'(trig_cnt), 32'd1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
